hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and data-memory freeze.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned REDIRECT_CYC = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    localparam logic [3:0] LP_RELOAD = 4'(REDIRECT_CYC - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_loadUse;
    logic       w_branchAccept;

    // XZR (register 31) is never a real producer, so it cannot create a hazard.
    assign w_loadUse = ex_memread && (ex_rd != 5'd31) &&
                       ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

    assign w_branchAccept = (r_state == ST_RUN) && !mem_busy && ex_branch_taken;

    assign state = r_state;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (w_loadUse) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
        // Reset must silence every enable immediately, not at the next edge.
        if (!resetl) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_busy) begin
                        r_state <= ST_MEM_WAIT;
                    end else if (ex_branch_taken && (REDIRECT_CYC > 1)) begin
                        r_state <= ST_REDIRECT;
                        r_cnt   <= LP_RELOAD;
                    end
                end
                ST_REDIRECT: begin
                    if (!mem_busy) begin
                        if (r_cnt <= 4'd1) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_busy) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Both counters saturate rather than wrap so long runs never read as small.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!pc_write && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_branchAccept && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    logic w_unusedPerf;
    assign w_unusedPerf = w_branchAccept;
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
`endif

endmodule
